// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter_pkg
//  Description : Shared constants for the register-bank write path: FSM
//                state encodings and default bus/bank widths. The sequencer
//                and bus arbiters reuse the same encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    // Default geometry of the A09 register bank and its requesters
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // Write-arbiter state encoding (fixed values, shared with other blocks)
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ACK  = 2'b10
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter_rr_pick
//  Description : Purely combinational round-robin picker. Scans the request
//                vector starting at Ptr and wrapping modulo NumReq; reports
//                the first requester found and whether any was found.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter_rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NumReq = DEF_NUM_REQ
) (
    input  logic [NumReq-1:0]         Req,
    input  logic [$clog2(NumReq)-1:0] Ptr,
    output logic [$clog2(NumReq)-1:0] Winner,
    output logic                      Valid
);

    localparam int                   c_ptr_width = $clog2(NumReq);
    localparam logic [c_ptr_width-1:0] c_last    = c_ptr_width'(NumReq - 1);
    localparam logic [c_ptr_width-1:0] c_one     = c_ptr_width'(1);

    logic [c_ptr_width-1:0] w_cand;

    // Walk the candidates Ptr, Ptr+1, ... (mod NumReq); first hit wins
    always_comb begin
        Winner = '0;
        Valid  = 1'b0;
        w_cand = Ptr;
        for (int i = 0; i < NumReq; i++) begin
            if (!Valid && Req[w_cand]) begin
                Valid  = 1'b1;
                Winner = w_cand;
            end
            w_cand = (w_cand == c_last) ? '0 : w_cand + c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter for the write side of a Register bank.
//                Grants one requester at a time, drives the shared DIn bus and
//                the active-low one-hot LD strobes for one cycle (LOAD), then
//                pulses Ack to the winner for one cycle (ACK). All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int NumReq    = DEF_NUM_REQ,
    parameter int NumRegs   = DEF_NUM_REGS,
    parameter int AddrWidth = DEF_ADDR_WIDTH
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumReq-1:0]             Req,
    input  logic [NumReq*AddrWidth-1:0]   ReqAddr,
    input  logic [NumReq*DataWidth-1:0]   ReqData,
    output logic [NumReq-1:0]             Ack,
    output logic [NumRegs-1:0]            LD,
    output logic [DataWidth-1:0]          DIn,
    output logic                          Busy
);

    localparam int                     c_ptr_width = $clog2(NumReq);
    localparam logic [c_ptr_width-1:0] c_last_req  = c_ptr_width'(NumReq - 1);
    localparam logic [c_ptr_width-1:0] c_ptr_one   = c_ptr_width'(1);
    localparam logic [NumRegs-1:0]     c_one_reg   = {{(NumRegs-1){1'b0}}, 1'b1};
    localparam logic [NumReq-1:0]      c_one_req   = {{(NumReq-1){1'b0}}, 1'b1};

    arb_state_t             r_state;
    logic [c_ptr_width-1:0] r_ptr;
    logic [c_ptr_width-1:0] r_winner;

    logic [c_ptr_width-1:0] w_winner;
    logic                   w_valid;
    logic [c_ptr_width-1:0] w_next_ptr;
    logic [AddrWidth-1:0]   w_addr;
    logic [DataWidth-1:0]   w_data;

    reg_write_arbiter_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .Req    (Req),
        .Ptr    (r_ptr),
        .Winner (w_winner),
        .Valid  (w_valid)
    );

    // Select the candidate winner's address/data slice and the pointer it implies
    always_comb begin
        w_addr     = ReqAddr[w_winner*AddrWidth +: AddrWidth];
        w_data     = ReqData[w_winner*DataWidth +: DataWidth];
        w_next_ptr = (w_winner == c_last_req) ? '0 : w_winner + c_ptr_one;
    end

    // IDLE -> LOAD -> ACK -> IDLE; every output is a register so no Req-to-LD/Ack path exists
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            LD       <= '1;
            DIn      <= '0;
            Ack      <= '0;
            Busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    Ack <= '0;
                    LD  <= '1;
                    if (w_valid) begin
                        // The LD and DIn registers double as the latched address and data
                        r_winner <= w_winner;
                        r_ptr    <= w_next_ptr;
                        LD       <= ~(c_one_reg << w_addr);
                        DIn      <= w_data;
                        Busy     <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Register captured the data at this edge; release the strobe
                    LD      <= '1;
                    Ack     <= c_one_req << r_winner;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    Ack     <= '0;
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    LD      <= '1;
                    Ack     <= '0;
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Scoreboard bench for reg_write_arbiter driving a bank of
//                eight 16-bit registers modelled in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int NG = 8;
    localparam int AW = 3;

    logic             Clk   = 1'b0;
    logic             Reset = 1'b0;
    logic [NR-1:0]    Req     = '0;
    logic [NR*AW-1:0] ReqAddr = '0;
    logic [NR*DW-1:0] ReqData = '0;
    logic [NR-1:0]    Ack;
    logic [NG-1:0]    LD;
    logic [DW-1:0]    DIn;
    logic             Busy;

    logic [DW-1:0]    regs [NG];

    int tests = 0;
    int fails = 0;
    int rem [NR];

    typedef struct {
        logic [NR-1:0] ack;
        logic [NG-1:0] ld;
        logic [DW-1:0] data;
        int            addr;
    } exp_t;

    exp_t sb[$];

    reg_write_arbiter #(
        .DataWidth (DW),
        .NumReq    (NR),
        .NumRegs   (NG),
        .AddrWidth (AW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .Ack     (Ack),
        .LD      (LD),
        .DIn     (DIn),
        .Busy    (Busy)
    );

    // 200 ns clock
    always #100 Clk = ~Clk;

    // Register bank: load on active-low LD, cleared by the shared reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NG; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < NG; k++) if (!LD[k]) regs[k] <= DIn;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int w, input int addr, input logic [DW-1:0] data);
        exp_t e;
        e.ack       = '0;
        e.ack[w]    = 1'b1;
        e.ld        = '1;
        e.ld[addr]  = 1'b0;
        e.data      = data;
        e.addr      = addr;
        return e;
    endfunction

    task automatic set_req(input int i, input int addr, input logic [DW-1:0] data, input int n);
        ReqAddr[i*AW +: AW] = AW'(addr);
        ReqData[i*DW +: DW] = data;
        rem[i]              = n;
        Req[i]              = 1'b1;
    endtask

    // Requester behaviour: count acks, drop Req once the last wanted ack is seen
    task automatic service(input int max_cycles);
        int cyc = 0;
        while (((|Req) || sb.size() != 0) && cyc < max_cycles) begin
            @(negedge Clk);
            for (int i = 0; i < NR; i++) begin
                if (Ack[i]) begin
                    if (rem[i] > 0) rem[i]--;
                    if (rem[i] == 0) Req[i] = 1'b0;
                end
            end
            cyc++;
        end
        if (cyc >= max_cycles) begin
            tests++;
            fails++;
            $display("FAIL service_timeout: got %0d pending expected 0", sb.size());
            Req = '0;
            sb.delete();
        end
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Monitor: compare LOAD cycles against the head entry, pop on Ack
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset) begin
                if (LD != '1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_load", {24'd0, LD}, 32'h0000_00FF);
                    end else begin
                        check("load_ld",   {24'd0, LD}, {24'd0, sb[0].ld});
                        check("load_din",  {16'd0, DIn}, {16'd0, sb[0].data});
                        check("load_busy", {31'd0, Busy}, 32'd1);
                    end
                end
                if (Ack != '0) begin
                    check("ack_ld_idle", {24'd0, LD}, 32'h0000_00FF);
                    if (sb.size() == 0) begin
                        check("unexpected_ack", {28'd0, Ack}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("ack_onehot", {28'd0, Ack}, {28'd0, e.ack});
                        check("ack_reg_dout", {16'd0, regs[e.addr]}, {16'd0, e.data});
                        check("ack_din_hold", {16'd0, DIn}, {16'd0, e.data});
                        check("ack_busy", {31'd0, Busy}, 32'd1);
                    end
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        bit seen;
        for (int i = 0; i < NR; i++) rem[i] = 0;

        // Reset held for 2 cycles
        repeat (2) @(posedge Clk);
        #1;
        check("reset_ld",   {24'd0, LD}, 32'h0000_00FF);
        check("reset_din",  {16'd0, DIn}, 32'd0);
        check("reset_ack",  {28'd0, Ack}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        for (int k = 0; k < NG; k++) check("reset_reg", {16'd0, regs[k]}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        // Single write: requester 1 -> register 3
        sb.push_back(mk(1, 3, 16'h00A0));
        set_req(1, 3, 16'h00A0, 1);
        service(30);
        check("single_reg3", {16'd0, regs[3]}, 32'h0000_00A0);
        for (int k = 0; k < NG; k++)
            if (k != 3) check("single_other_reg", {16'd0, regs[k]}, 32'd0);

        // Contention from P=0: 0,1,2,3 then each once more
        reset_pulse();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) sb.push_back(mk(i, i, 16'h1000 + 16'(i)));
        for (int i = 0; i < NR; i++) set_req(i, i, 16'h1000 + 16'(i), 2);
        service(60);
        for (int i = 0; i < NR; i++)
            check("contention_reg", {16'd0, regs[i]}, 32'h0000_1000 + 32'(i));

        // Fairness: 0 and 2 keep re-requesting, grants must alternate
        @(negedge Clk);
        for (int r = 0; r < 3; r++) begin
            sb.push_back(mk(0, 6, 16'h0606));
            sb.push_back(mk(2, 7, 16'h0707));
        end
        set_req(0, 6, 16'h0606, 3);
        set_req(2, 7, 16'h0707, 3);
        service(60);
        check("fair_reg6", {16'd0, regs[6]}, 32'h0000_0606);
        check("fair_reg7", {16'd0, regs[7]}, 32'h0000_0707);

        // Same target from P=0: requester 1 is serviced last and wins
        reset_pulse();
        sb.push_back(mk(0, 5, 16'hAAAA));
        sb.push_back(mk(1, 5, 16'h5555));
        set_req(0, 5, 16'hAAAA, 1);
        set_req(1, 5, 16'h5555, 1);
        service(30);
        check("same_target_reg5", {16'd0, regs[5]}, 32'h0000_5555);

        // Reset mid-LOAD: write abandoned, then completes after release
        @(negedge Clk);
        sb.push_back(mk(3, 2, 16'hBEEF));
        set_req(3, 2, 16'hBEEF, 1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge Clk);
            #1;
            if (LD != '1) seen = 1'b1;
        end
        check("midload_seen", {31'd0, seen}, 32'd1);
        #20;
        Reset = 1'b0;
        #1;
        check("midload_ld",   {24'd0, LD}, 32'h0000_00FF);
        check("midload_ack",  {28'd0, Ack}, 32'd0);
        check("midload_busy", {31'd0, Busy}, 32'd0);
        check("midload_reg2", {16'd0, regs[2]}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        service(30);
        check("midload_retry_reg2", {16'd0, regs[2]}, 32'h0000_BEEF);
        check("scoreboard_empty", sb.size(), 32'd0);
        repeat (3) @(negedge Clk);
        check("idle_busy", {31'd0, Busy}, 32'd0);
        check("idle_ld",   {24'd0, LD}, 32'h0000_00FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
